// File: rtl/elastic_skid_stage.sv
// elastic_skid_stage
//   One registered skid stage of an elastic valid/ready pipeline.
//   The main register drives the downstream side. The skid register catches
//   the beat accepted in the cycle the downstream side stalls, so the
//   upstream ready can be a pure register output.
//
// Ports:
//   CLK          rising-edge clock
//   RST_N        asynchronous active-low reset (clears valids and data)
//   FLUSH        synchronous kill of both valid bits; data is kept
//   i_up_valid   upstream beat present
//   o_up_ready   stage can accept a beat (= !skid_valid)
//   i_up_data    upstream payload
//   o_down_valid main register holds a beat
//   i_down_ready downstream accepts the beat
//   o_down_data  main register payload
module elastic_skid_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             FLUSH,
  input  logic             i_up_valid,
  output logic             o_up_ready,
  input  logic [WIDTH-1:0] i_up_data,
  output logic             o_down_valid,
  input  logic             i_down_ready,
  output logic [WIDTH-1:0] o_down_data
);

  logic [WIDTH-1:0] r_main;
  logic             r_main_valid;
  logic [WIDTH-1:0] r_skid;
  logic             r_skid_valid;

  logic w_up_fire;
  logic w_take;

  assign o_up_ready   = !r_skid_valid;
  assign o_down_valid = r_main_valid;
  assign o_down_data  = r_main;

  assign w_up_fire = i_up_valid && !r_skid_valid;
  assign w_take    = r_main_valid && i_down_ready;

  // State is encoded by the valid pair: EMPTY (0,0), HALF (1,0), FULL (1,1).
  // When main is free or being taken, refill it from skid first (FULL->HALF),
  // otherwise from the upstream beat; if main is stalled, the upstream beat
  // goes to skid (HALF->FULL).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_main       <= '0;
      r_main_valid <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else if (FLUSH) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid || w_take) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_up_fire) begin
        r_main       <= i_up_data;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_up_fire) begin
      r_skid       <= i_up_data;
      r_skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg
//   Chain of CYCLES skid stages with a valid/ready handshake. Every ready is
//   a register output, so there is no combinational path from out_ready to
//   in_ready. Capacity is 2*CYCLES beats, strict FIFO order.
//
// Parameters:
//   CYCLES  number of skid stages (>=1), minimum latency in clocks
//   WIDTH   payload width in bits
//
// Ports:
//   CLK        rising-edge clock
//   RST_N      asynchronous active-low reset
//   FLUSH      synchronous kill of all in-flight beats
//   in_valid   producer has a beat on in
//   in_ready   block accepts a beat this cycle
//   in         input payload
//   out_valid  beat present on out
//   out_ready  consumer accepts the beat this cycle
//   out        output payload
module elastic_pipe_reg #(
  parameter int unsigned CYCLES = 1,
  parameter int unsigned WIDTH  = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             FLUSH,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  // Index i is the link into stage i; index CYCLES is the chain output.
  logic             w_valid [CYCLES+1];
  logic             w_ready [CYCLES+1];
  logic [WIDTH-1:0] w_data  [CYCLES+1];

  assign w_valid[0]      = in_valid;
  assign w_data[0]       = in;
  assign in_ready        = w_ready[0];
  assign out_valid       = w_valid[CYCLES];
  assign out             = w_data[CYCLES];
  assign w_ready[CYCLES] = out_ready;

  for (genvar g = 0; g < CYCLES; g++) begin : g_stage
    elastic_skid_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .FLUSH        (FLUSH),
      .i_up_valid   (w_valid[g]),
      .o_up_ready   (w_ready[g]),
      .i_up_data    (w_data[g]),
      .o_down_valid (w_valid[g+1]),
      .i_down_ready (w_ready[g+1]),
      .o_down_data  (w_data[g+1])
    );
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
module tb_elastic_pipe_reg;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        FLUSH;
  // Instance k has CYCLES = k+1.
  logic        iv   [3];
  logic        irdy [3];
  logic [31:0] din  [3];
  logic        ov   [3];
  logic        ordy [3];
  logic [31:0] dout [3];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  elastic_pipe_reg #(.CYCLES(1), .WIDTH(32)) u_c1 (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
    .in_valid(iv[0]), .in_ready(irdy[0]), .in(din[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out(dout[0]));

  elastic_pipe_reg #(.CYCLES(2), .WIDTH(32)) u_c2 (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
    .in_valid(iv[1]), .in_ready(irdy[1]), .in(din[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out(dout[1]));

  elastic_pipe_reg #(.CYCLES(3), .WIDTH(32)) u_c3 (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
    .in_valid(iv[2]), .in_ready(irdy[2]), .in(din[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out(dout[2]));

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] sv_dat [7];
  logic        se_v   [7];
  logic [31:0] se_d   [7];
  logic [31:0] fd_in  [6];
  logic        fe_r   [6];
  logic        fe_v   [6];
  logic [31:0] de_d   [5];
  logic        de_v   [5];
  logic        de_r   [5];
  logic [31:0] q [$];
  logic        hold;
  logic        f_in, f_out;
  logic [31:0] d_in, d_out;

  initial begin
    RST_N = 1'b0;
    FLUSH = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; din[k] = '0; ordy[k] = 1'b0;
    end
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ov%0d", k), {31'd0, ov[k]}, 32'd0);
      chk($sformatf("rst_out%0d", k), dout[k], 32'd0);
      chk($sformatf("rst_irdy%0d", k), {31'd0, irdy[k]}, 32'd1);
    end
    #10 RST_N = 1'b1;
    step();

    // Streaming, CYCLES=3, consumer always ready.
    sv_dat = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h0, 32'h0, 32'h0};
    se_v   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    se_d   = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h44, 32'h0};
    ordy[2] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      iv[2]  = (k < 4);
      din[2] = sv_dat[k];
      chk($sformatf("stream_irdy%0d", k), {31'd0, irdy[2]}, 32'd1);
      step();
      chk($sformatf("stream_ov%0d", k), {31'd0, ov[2]}, {31'd0, se_v[k]});
      if (se_v[k]) chk($sformatf("stream_out%0d", k), dout[2], se_d[k]);
    end
    ordy[2] = 1'b0;

    // Fill, CYCLES=2, consumer stalled: exactly 4 beats fit.
    fd_in = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA4};
    fe_r  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    fe_v  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 6; k++) begin
      iv[1]  = 1'b1;
      din[1] = fd_in[k];
      step();
      chk($sformatf("fill_irdy%0d", k), {31'd0, irdy[1]}, {31'd0, fe_r[k]});
      chk($sformatf("fill_ov%0d", k), {31'd0, ov[1]}, {31'd0, fe_v[k]});
      if (fe_v[k]) chk($sformatf("fill_out%0d", k), dout[1], 32'hA0);
    end
    // Drain with A4 still offered; in_ready comes back one cycle after the first take.
    de_d = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'h0};
    de_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    de_r = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ordy[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      iv[1] = (k < 3);
      step();
      chk($sformatf("drain_irdy%0d", k), {31'd0, irdy[1]}, {31'd0, de_r[k]});
      chk($sformatf("drain_ov%0d", k), {31'd0, ov[1]}, {31'd0, de_v[k]});
      if (de_v[k]) chk($sformatf("drain_out%0d", k), dout[1], de_d[k]);
    end
    iv[1] = 1'b0;

    // Stall stability, CYCLES=1.
    ordy[0] = 1'b0;
    iv[0]   = 1'b1;
    din[0]  = 32'hDEADBEEF;
    step();
    iv[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      din[0] = ~din[0] ^ 32'(k);
      chk($sformatf("stall_ov%0d", k), {31'd0, ov[0]}, 32'd1);
      chk($sformatf("stall_out%0d", k), dout[0], 32'hDEADBEEF);
      step();
    end
    chk("stall_irdy", {31'd0, irdy[0]}, 32'd1);
    ordy[0] = 1'b1;
    step();
    chk("stall_done_ov", {31'd0, ov[0]}, 32'd0);

    // Flush, CYCLES=2, three beats in flight, beat 0x55 offered with FLUSH.
    ordy[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[1]  = 1'b1;
      din[1] = 32'hB1 + 32'(k);
      step();
    end
    chk("flush_pre_ov", {31'd0, ov[1]}, 32'd1);
    chk("flush_pre_irdy", {31'd0, irdy[1]}, 32'd1);
    FLUSH  = 1'b1;
    din[1] = 32'h55;
    step();
    FLUSH   = 1'b0;
    iv[1]   = 1'b0;
    ordy[1] = 1'b1;
    chk("flush_ov", {31'd0, ov[1]}, 32'd0);
    chk("flush_irdy", {31'd0, irdy[1]}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("flush_quiet%0d", k), {31'd0, ov[1]}, 32'd0);
    end
    iv[1]  = 1'b1;
    din[1] = 32'h66;
    step();
    iv[1] = 1'b0;
    chk("postflush_ov0", {31'd0, ov[1]}, 32'd0);
    step();
    chk("postflush_ov1", {31'd0, ov[1]}, 32'd1);
    chk("postflush_out", dout[1], 32'h66);
    step();

    // Asynchronous reset mid-cycle with beats in flight, CYCLES=3.
    ordy[2] = 1'b0;
    iv[2] = 1'b1; din[2] = 32'hC1; step();
    din[2] = 32'hC2; step();
    iv[2] = 1'b0; step();
    chk("arst_pre_ov", {31'd0, ov[2]}, 32'd1);
    #3 RST_N = 1'b0;
    #1;
    chk("arst_ov", {31'd0, ov[2]}, 32'd0);
    chk("arst_out", dout[2], 32'd0);
    chk("arst_irdy", {31'd0, irdy[2]}, 32'd1);
    #2 RST_N = 1'b1;
    iv[2] = 1'b1; din[2] = 32'h77; ordy[2] = 1'b1;
    step();
    iv[2] = 1'b0;
    chk("arst_rel_ov0", {31'd0, ov[2]}, 32'd0);
    step();
    chk("arst_rel_ov1", {31'd0, ov[2]}, 32'd0);
    step();
    chk("arst_rel_ov2", {31'd0, ov[2]}, 32'd1);
    chk("arst_rel_out", dout[2], 32'h77);
    step();

    // Random traffic on CYCLES=2 against a FIFO scoreboard.
    hold = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!hold) begin
        iv[1] = 1'($urandom_range(0, 1));
        if (iv[1]) din[1] = $urandom;
      end
      ordy[1] = 1'($urandom_range(0, 1));
      f_in  = iv[1] && irdy[1];
      f_out = ov[1] && ordy[1];
      d_in  = din[1];
      d_out = dout[1];
      step();
      if (f_out) begin
        if (q.size() == 0) chk("rnd_spurious", {31'd0, f_out}, 32'd0);
        else chk("rnd_data", d_out, q.pop_front());
      end
      if (f_in) q.push_back(d_in);
      hold = iv[1] && !f_in;
      n_assert++;
      assert (q.size() <= 4) else begin
        n_fail++;
        $error("FAIL rnd_occupancy observed=%0d expected<=%0d", q.size(), 4);
      end
    end
    iv[1]   = 1'b0;
    ordy[1] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      f_out = ov[1];
      d_out = dout[1];
      step();
      if (f_out) begin
        if (q.size() == 0) chk("rnd_drain_spurious", {31'd0, f_out}, 32'd0);
        else chk("rnd_drain_data", d_out, q.pop_front());
      end
    end
    chk("rnd_lost", 32'(q.size()), 32'd0);
    chk("rnd_final_ov", {31'd0, ov[1]}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/elastic_pipe_reg.md
Name: elastic_pipe_reg

Overview:
Multi-stage pipeline register with a valid/ready handshake. It carries the backpressure (ready) direction that the plain enable-driven delay line lacks.
- Each stage is a registered skid stage, so ready never forms a combinational path from out_ready back to in_ready.
- Used between Otter pipeline stages and on memory response paths, where the consumer can stall independently of the producer.

Parameters:
- CYCLES, 1, number of skid stages in the chain (>=1); minimum input-to-output latency in clocks.
- WIDTH, 32, payload width in bits.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- FLUSH  in  1  synchronous kill of all in-flight beats.
- in_valid  in  1  producer has a beat on in.
- in_ready  out  1  block accepts a beat this cycle.
- in  in  WIDTH  input payload.
- out_valid  out  1  beat present on out.
- out_ready  in  1  consumer accepts the beat this cycle.
- out  out  WIDTH  output payload.

Behaviour:
- Interface: one clock CLK; reset RST_N is asynchronous and active-low.
- Handshake:
  - A transfer occurs on a rising CLK edge when valid && ready on that side.
  - A producer holding valid may not change payload until the transfer.
  - The block obeys the same rule on out: once out_valid=1, out and out_valid stay stable until out_ready=1 or FLUSH=1.
- Reset (RST_N=0, asynchronous): every stage main and skid valid=0 and all data registers=0. Therefore out_valid=0, out=0, in_ready=1.
- Reset release mid-traffic: everything in flight is lost. The first accept is possible on the first edge after release.
- Each stage holds:
  - main register + main_valid, which drives the stage output;
  - skid register + skid_valid.
  - Stage ready_up = !skid_valid. It is a pure register output.
- Stage states: EMPTY (main=0, skid=0), HALF (main=1, skid=0), FULL (main=1, skid=1).
  - EMPTY, accept -> HALF.
  - HALF: accept && downstream takes -> HALF (main reloads). Accept, no take -> FULL (beat goes to skid). Take, no accept -> EMPTY.
  - FULL: accept impossible (ready_up=0). Take -> HALF, skid moves to main.
- Chain wiring: stage i output valid/data feed stage i+1 input; stage i+1 ready_up feeds stage i downstream-ready. Stage 0 connects to in/in_ready; stage CYCLES-1 connects to out/out_valid/out_ready.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+CYCLES-1 when all stages are empty. Throughput is 1 beat/clock when out_ready is held at 1.
- Ordering: strict FIFO and lossless. Capacity = 2*CYCLES beats.
- Full condition: with out_ready=0 held, in_ready drops after exactly 2*CYCLES accepted beats.
- Simultaneous accept and take on a full chain: in_ready is registered and reflects only the prior cycle, so no beat is accepted that cycle. in_ready rises the following cycle.
- FLUSH=1 at an edge:
  - clears all main and skid valid bits; data registers keep their values;
  - drops any beat presented on in that cycle, even if in_ready=1;
  - does not count any out transfer that cycle as delivered to the block's state.
  - After FLUSH: out_valid=0 and in_ready=1 at the next cycle.
- FLUSH while RST_N=0: no effect (reset dominates).
- Width rules: payload passes through unmodified; no arithmetic.

Decomposition:
- No shared package needed; the only constants are the parameters. The stage state type is local (valid bits encode it).
- One sub-module, elastic_skid_stage (WIDTH; CLK, RST_N, FLUSH, up/down valid-ready-data). It is instantiated CYCLES times in a generate loop by elastic_pipe_reg.

Test Plan:
- Reset: RST_N=0 asynchronously mid-cycle with beats in flight -> out_valid=0, out=0, in_ready=1 immediately, without waiting for a clock edge.
- Streaming, CYCLES=3, out_ready=1: beats 0x11,0x22,0x33,0x44 on consecutive edges -> out shows the same order. First out_valid is 2 cycles after accepting 0x11, then one beat per cycle with no bubbles.
- Fill, CYCLES=2, out_ready=0, in_valid=1 with 0xA0..0xA5 -> exactly 4 beats accepted and in_ready=0 afterwards. Then out_ready=1 -> 0xA0,0xA1,0xA2,0xA3 emerge in order, and in_ready returns to 1 one cycle after the first take.
- Stall stability, CYCLES=1: out_valid=1 with out=0xDEADBEEF, toggle in payload with out_ready=0 for 5 cycles -> out holds 0xDEADBEEF and out_valid stays 1.
- Flush, CYCLES=2, 3 beats in flight, FLUSH=1 with in_valid=1 and in=0x55 -> the next cycle out_valid=0 and in_ready=1; 0x55 never appears on out.
- Random: random in_valid/out_ready at 50% for 10k cycles -> scoreboard shows no loss, duplication, or reordering, and the in-flight count never exceeds 2*CYCLES.
